ibex_rfctx_sched: RTL and testbench

- Context scheduler that drives the register-file cache's `rf_sel` input.
- Decides which register-file context is active and when to switch: on time-slice expiry, on a core yield, or on an explicit software request.
- Sequences each switch in order: drain the core, retarget `rf_sel`, wait for the cache's spill/fill to finish, release the core.
- Sits between the core control logic (halt/ack, yield, CSR writes) and the register-file cache.

---
 rtl/ibex_rfctx_sched.sv | 184 ++++++++++++++++++
 tb/tb_ibex_rfctx_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rfctx_sched.sv
// Register-file context scheduler: picks the active context and sequences
// each switch (drain core, retarget rf_sel, wait for spill/fill, release core).
module ibex_rfctx_sched #(
    parameter int unsigned NumContexts = 4,
    parameter logic [31:0] CtxBase     = 32'h0001_0000,
    parameter logic [31:0] CtxStride   = 32'h0000_0080,
    parameter int unsigned BootCtx     = 0,
    localparam int unsigned CW         = (NumContexts > 1) ? $clog2(NumContexts) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumContexts-1:0] ctx_en_i,
    input  logic [15:0]            quantum_i,
    input  logic                   yield_i,
    input  logic                   sw_sel_valid_i,
    input  logic [CW-1:0]          sw_sel_idx_i,
    input  logic                   halt_ack_i,
    input  logic                   rf_busy_i,
    output logic                   halt_req_o,
    output logic [31:0]            rf_sel_o,
    output logic [CW-1:0]          cur_ctx_o,
    output logic                   switching_o,
    output logic                   sw_sel_err_o,
    output logic [15:0]            switch_cnt_o,
    output logic [1:0]             dbg_state_o
);

    // Handshakes: halt_req_o is a level held from the switch decision until the
    // fill completes; halt_ack_i is sampled only in DRAIN, rf_busy_i only in
    // SWITCH (rising) and FILL (falling). Software/yield strobes act only in RUN.

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StSwitch = 2'd2,
        StFill   = 2'd3
    } state_e;

    localparam int unsigned EnW     = 1 << CW;
    localparam logic [31:0] BootSel = CtxBase + 32'(BootCtx) * CtxStride;

    function automatic logic [31:0] ctx_addr(input logic [CW-1:0] idx);
        return CtxBase + 32'(idx) * CtxStride;
    endfunction

    state_e        state_q, state_d;
    logic [15:0]   qcnt_q, qcnt_d;
    logic [CW-1:0] tgt_q, tgt_d;
    logic [CW-1:0] cur_ctx_q, cur_ctx_d;
    logic [31:0]   rf_sel_q, rf_sel_d;
    logic          halt_req_q, halt_req_d;
    logic          sw_err_q, sw_err_d;
    logic [15:0]   switch_cnt_q, switch_cnt_d;

    // Padding to a power of two makes out-of-range software indices read as disabled.
    logic [EnW-1:0] en_pad;
    logic [CW-1:0]  cand;
    logic [CW-1:0]  rr_idx;
    logic           rr_found;
    logic           sw_ok;
    logic           trig;
    logic           trig_ok;
    logic [CW-1:0]  trig_tgt;

    assign en_pad = EnW'(ctx_en_i);
    assign sw_ok  = en_pad[sw_sel_idx_i];

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = cur_ctx_q;
        cand     = '0;
        for (int unsigned i = 1; i < NumContexts; i++) begin
            cand = CW'((32'(cur_ctx_q) + i) % NumContexts);
            if (!rr_found && en_pad[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        qcnt_d       = qcnt_q;
        tgt_d        = tgt_q;
        cur_ctx_d    = cur_ctx_q;
        rf_sel_d     = rf_sel_q;
        halt_req_d   = halt_req_q;
        sw_err_d     = 1'b0;
        switch_cnt_d = switch_cnt_q;
        trig         = 1'b0;
        trig_ok      = 1'b0;
        trig_tgt     = rr_idx;

        case (state_q)
            StRun: begin
                if (qcnt_q == 16'd0) begin
                    qcnt_d = quantum_i;
                end else if (qcnt_q > 16'd1) begin
                    qcnt_d = qcnt_q - 16'd1;
                end
                // A software strobe, even a rejected one, masks yield and expiry.
                if (sw_sel_valid_i) begin
                    if (!sw_ok) begin
                        sw_err_d = 1'b1;
                    end else begin
                        trig     = 1'b1;
                        trig_tgt = sw_sel_idx_i;
                        trig_ok  = (sw_sel_idx_i != cur_ctx_q);
                    end
                end else if (yield_i || (qcnt_q == 16'd1)) begin
                    trig     = 1'b1;
                    trig_tgt = rr_idx;
                    trig_ok  = rr_found;
                end
                if (trig) begin
                    if (trig_ok) begin
                        tgt_d      = trig_tgt;
                        halt_req_d = 1'b1;
                        state_d    = StDrain;
                    end else begin
                        qcnt_d = 16'd0;
                    end
                end
            end
            StDrain: begin
                sw_err_d = sw_sel_valid_i;
                if (halt_ack_i) begin
                    rf_sel_d  = ctx_addr(tgt_q);
                    cur_ctx_d = tgt_q;
                    state_d   = StSwitch;
                end
            end
            StSwitch: begin
                sw_err_d = sw_sel_valid_i;
                if (rf_busy_i) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                sw_err_d = sw_sel_valid_i;
                if (!rf_busy_i) begin
                    halt_req_d   = 1'b0;
                    switch_cnt_d = switch_cnt_q + 16'd1;
                    qcnt_d       = 16'd0;
                    state_d      = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StRun;
            qcnt_q       <= 16'd0;
            tgt_q        <= CW'(BootCtx);
            cur_ctx_q    <= CW'(BootCtx);
            rf_sel_q     <= BootSel;
            halt_req_q   <= 1'b0;
            sw_err_q     <= 1'b0;
            switch_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            qcnt_q       <= qcnt_d;
            tgt_q        <= tgt_d;
            cur_ctx_q    <= cur_ctx_d;
            rf_sel_q     <= rf_sel_d;
            halt_req_q   <= halt_req_d;
            sw_err_q     <= sw_err_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign halt_req_o   = halt_req_q;
    assign rf_sel_o     = rf_sel_q;
    assign cur_ctx_o    = cur_ctx_q;
    assign switching_o  = (state_q != StRun);
    assign sw_sel_err_o = sw_err_q;
    assign switch_cnt_o = switch_cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ibex_rfctx_sched.sv
// Bench for ibex_rfctx_sched: a core/cache model drives switch handshakes and
// a queue of expected {ctx, rf_sel} pairs is checked on every completed switch.
module tb_ibex_rfctx_sched;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int W  = 34;

  logic          clk;
  logic          rst_ni;
  logic [N-1:0]  ctx_en_i;
  logic [15:0]   quantum_i;
  logic          yield_i;
  logic          sw_sel_valid_i;
  logic [CW-1:0] sw_sel_idx_i;
  logic          halt_ack_i;
  logic          rf_busy_i;
  logic          halt_req_o;
  logic [31:0]   rf_sel_o;
  logic [CW-1:0] cur_ctx_o;
  logic          switching_o;
  logic          sw_sel_err_o;
  logic [15:0]   switch_cnt_o;
  logic [1:0]    dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [W-1:0] exp_q[$];

  ibex_rfctx_sched dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ctx_en_i       (ctx_en_i),
    .quantum_i      (quantum_i),
    .yield_i        (yield_i),
    .sw_sel_valid_i (sw_sel_valid_i),
    .sw_sel_idx_i   (sw_sel_idx_i),
    .halt_ack_i     (halt_ack_i),
    .rf_busy_i      (rf_busy_i),
    .halt_req_o     (halt_req_o),
    .rf_sel_o       (rf_sel_o),
    .cur_ctx_o      (cur_ctx_o),
    .switching_o    (switching_o),
    .sw_sel_err_o   (sw_sel_err_o),
    .switch_cnt_o   (switch_cnt_o),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int c);
    return 32'h0001_0000 + 32'(c) * 32'h0000_0080;
  endfunction

  function automatic logic [W-1:0] sb_entry(input int c);
    logic [CW-1:0] cc;
    cc = CW'(c);
    return {cc, addr_of(c)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cur"}, W'(cur_ctx_o), W'(0));
    chk({tag, "_sel"}, W'(rf_sel_o), W'(32'h0001_0000));
    chk({tag, "_halt"}, W'(halt_req_o), W'(0));
    chk({tag, "_swing"}, W'(switching_o), W'(0));
    chk({tag, "_err"}, W'(sw_sel_err_o), W'(0));
    chk({tag, "_cnt"}, W'(switch_cnt_o), W'(0));
  endtask

  // driver tasks
  task automatic apply_reset;
    rst_ni         = 1'b0;
    ctx_en_i       = '0;
    quantum_i      = '0;
    yield_i        = 1'b0;
    sw_sel_valid_i = 1'b0;
    sw_sel_idx_i   = '0;
    halt_ack_i     = 1'b0;
    rf_busy_i      = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) tick();
  endtask

  task automatic pulse_yield;
    yield_i = 1'b1;
    tick();
    yield_i = 1'b0;
  endtask

  // Core acks after ack_dly cycles; cache raises busy the cycle after the new
  // rf_sel appears and holds it for busy_len cycles.
  task automatic do_switch(input int ack_dly, input int busy_len);
    logic [31:0] sel0;
    logic [W-1:0] e;
    sel0 = rf_sel_o;
    repeat (ack_dly) begin
      tick();
      chk("sel_hold_drain", W'(rf_sel_o), W'(sel0));
      chk("halt_hold_drain", W'(halt_req_o), W'(1));
    end
    halt_ack_i = 1'b1;
    tick();
    halt_ack_i = 1'b0;
    chk("swing_after_ack", W'(switching_o), W'(1));
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("sel_after_ack", W'(rf_sel_o), W'(e[31:0]));
    end
    tick();
    chk("swing_switch", W'(switching_o), W'(1));
    rf_busy_i = 1'b1;
    repeat (busy_len) begin
      tick();
      chk("swing_fill", W'(switching_o), W'(1));
      chk("halt_fill", W'(halt_req_o), W'(1));
    end
    rf_busy_i = 1'b0;
    tick();
    chk("swing_done", W'(switching_o), W'(0));
    chk("halt_done", W'(halt_req_o), W'(0));
    exp_cnt++;
    chk("switch_cnt", W'(switch_cnt_o), W'(exp_cnt));
    // scoreboard pop
    if (exp_q.size() == 0) begin
      chk("sb_underflow", W'(0), W'(1));
    end else begin
      e = exp_q.pop_front();
      chk("sb_ctx_sel", {cur_ctx_o, rf_sel_o}, e);
    end
  endtask

  initial begin
    apply_reset();
    #1;
    check_reset_state("rst");

    // Single runnable context: expiries never switch.
    ctx_en_i  = 4'b0001;
    quantum_i = 16'd3;
    rst_ni    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("solo_halt", W'(halt_req_o), W'(0));
    end
    chk("solo_cnt", W'(switch_cnt_o), W'(0));
    chk("solo_cur", W'(cur_ctx_o), W'(0));
    quantum_i = 16'd0;
    repeat (5) tick();

    // Software request beats a simultaneous yield; slow ack, long fill.
    ctx_en_i       = 4'b1111;
    sw_sel_valid_i = 1'b1;
    sw_sel_idx_i   = 2'd2;
    yield_i        = 1'b1;
    exp_q.push_back(sb_entry(2));
    tick();
    sw_sel_valid_i = 1'b0;
    yield_i        = 1'b0;
    chk("sw_halt", W'(halt_req_o), W'(1));
    chk("sw_noerr", W'(sw_sel_err_o), W'(0));
    do_switch(5, 64);
    chk("sw_sel_val", W'(rf_sel_o), W'(32'h0001_0100));
    repeat (3) begin
      tick();
      chk("yield_dropped", W'(halt_req_o), W'(0));
    end

    // Request to a disabled context is rejected.
    ctx_en_i       = 4'b0111;
    sw_sel_valid_i = 1'b1;
    sw_sel_idx_i   = 2'd3;
    tick();
    sw_sel_valid_i = 1'b0;
    chk("rej_err", W'(sw_sel_err_o), W'(1));
    chk("rej_swing", W'(switching_o), W'(0));
    chk("rej_halt", W'(halt_req_o), W'(0));
    tick();
    chk("rej_err_clr", W'(sw_sel_err_o), W'(0));
    chk("rej_sel", W'(rf_sel_o), W'(addr_of(2)));

    // Yield from ctx 2 wraps past disabled ctx 3 to ctx 0.
    exp_q.push_back(sb_entry(0));
    pulse_yield();
    chk("wrap_halt", W'(halt_req_o), W'(1));
    do_switch(0, 2);

    // Request for the current context: no switch, no error.
    sw_sel_valid_i = 1'b1;
    sw_sel_idx_i   = 2'd0;
    tick();
    sw_sel_valid_i = 1'b0;
    chk("self_halt", W'(halt_req_o), W'(0));
    chk("self_err", W'(sw_sel_err_o), W'(0));

    // Strobes during DRAIN: error pulse, latched target unaffected by ctx_en.
    exp_q.push_back(sb_entry(1));
    pulse_yield();
    chk("drain_halt", W'(halt_req_o), W'(1));
    ctx_en_i       = 4'b0000;
    sw_sel_valid_i = 1'b1;
    sw_sel_idx_i   = 2'd2;
    yield_i        = 1'b1;
    tick();
    sw_sel_valid_i = 1'b0;
    yield_i        = 1'b0;
    chk("drain_err", W'(sw_sel_err_o), W'(1));
    do_switch(1, 3);
    ctx_en_i = 4'b0111;

    // Quantum expiry timing from reset.
    apply_reset();
    #1;
    check_reset_state("rst2");
    ctx_en_i  = 4'b0011;
    quantum_i = 16'd10;
    rst_ni    = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("q_pre_halt", W'(halt_req_o), W'(0));
    end
    tick();
    chk("q_fire_halt", W'(halt_req_o), W'(1));
    chk("q_fire_swing", W'(switching_o), W'(1));
    quantum_i = 16'd0;
    exp_q.push_back(sb_entry(1));
    do_switch(0, 1);
    chk("q_sel", W'(rf_sel_o), W'(32'h0001_0080));
    chk("q_cur", W'(cur_ctx_o), W'(1));

    // Reset in the middle of FILL.
    ctx_en_i = 4'b0111;
    pulse_yield();
    chk("mid_halt", W'(halt_req_o), W'(1));
    halt_ack_i = 1'b1;
    tick();
    halt_ack_i = 1'b0;
    chk("mid_sel", W'(rf_sel_o), W'(addr_of(2)));
    tick();
    rf_busy_i = 1'b1;
    repeat (2) tick();
    rst_ni    = 1'b0;
    rf_busy_i = 1'b0;
    #1;
    check_reset_state("mid_rst");
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_swing", W'(switching_o), W'(0));
    chk("post_rst_halt", W'(halt_req_o), W'(0));

    chk("sb_drained", W'(exp_q.size()), W'(0));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
